zbank_bus_sequencer: RTL
========================

// Module: zbank_bus_sequencer
// PURPOSE
//  Sequences Z80 accesses through the 32 KB bank window (Z80 0x8000-0xFFFF) onto the 68k bus.
//  Holds a 9-bit bank shift register, loaded one bit at a time by Z80 writes to 0x6000.
//  Stalls the Z80 with WAIT, then requests and acquires the 68k bus.
//  Runs a single byte cycle with DTACK handshake, returns the read data and releases the bus.
//  Sits beside the 68k/Z80 arbiter in the chip top; its outputs OR into the shared VA/VD and strobe nets.
// PARAMETERS
//  STROBE_SETUP   2    MCLK cycles from address drive to AS/DS assertion (1..7)
//  DTACK_TIMEOUT  255  MCLK cycles in STROBE before a forced finish (only with ZBANK_TIMEOUT_EN)
// PORTS
//  MCLK        in   1   master clock; all state changes on the rising edge
//  SRES        in   1   reset: synchronous, active-low
//  zreq        in   1   Z80 window access request (decoded MREQ & A15); level, held until zwait drops
//  zwr         in   1   1 = write, 0 = read; sampled with zreq
//  za          in   15  Z80 address [14:0]
//  zd_i        in   8   Z80 write data
//  zd_o        out  8   read data to the Z80; valid while zdone=1
//  zdone       out  1   one-cycle pulse: access complete
//  WAIT_pull   out  1   1 = pull Z80 WAIT low
//  bank_wr     in   1   one-cycle pulse: Z80 write to 0x6000
//  bank_bit    in   1   ZD[0] for that write
//  BR_pull     out  1   1 = assert 68k BR
//  BG          in   1   68k bus grant, active-low
//  BGACK_i     in   1   bus-acknowledge line, active-low (other master)
//  BGACK_pull  out  1   1 = assert BGACK
//  AS_i        in   1   address strobe line, active-low
//  va_o        out  23  word address: {bank[8:0], za[14:1]}
//  vd_i        in   16  68k data bus
//  vd_o        out  16  write data {zd,zd}
//  bus_d       out  1   1 = address/data/strobes released (input); 0 = driven
//  vd_d        out  1   1 = data released; 0 only during a write in STROBE
//  as_o, uds_o, lds_o, rw_o  out 1 each  68k strobes (active-low); rw 1 = read
//  DTACK_i     in   1   active-low
//  timeout_err out  1   sticky; set when a cycle ends by timeout, cleared by reset
// BEHAVIOUR
//  Reset (SRES=0 at edge): state=IDLE, bank=0, all *_pull=0, bus_d=1, vd_d=1, strobes=1, rw_o=1,
//  zd_o=8'hFF, zdone=0, timeout_err=0. Taking effect mid-cycle releases the bus on the next edge.
//  Bank: on bank_wr, bank <= {bank_bit, bank[8:1]}; updates in any state.
//  The in-flight access uses the address latched at IDLE->REQ.
//  FSM:
//   IDLE:    zreq=1 -> latch za/zwr/zd_i/bank, WAIT_pull=1 in the same cycle, -> REQ.
//   REQ:     BR_pull=1; BG=0 & BGACK_i=1 & AS_i=1 sampled -> OWN.
//   OWN:     BGACK_pull=1, BR_pull=0, bus_d=0, va_o driven; after STROBE_SETUP cycles -> STROBE.
//   STROBE:  as_o=0; uds_o=0 if za[0]=0, else lds_o=0; rw_o=~zwr; write: vd_d=0.
//            DTACK_i=0 sampled -> read latches vd_i[15:8] (za[0]=0) or vd_i[7:0] -> END.
//   END:     strobes=1, vd_d=1; next cycle bus_d=1, BGACK_pull=0, WAIT_pull=0, zdone=1 -> IDLE.
//  Latency with BG immediate and DTACK immediate: zreq to zdone = 4+STROBE_SETUP cycles.
//  zreq high in IDLE in the cycle after zdone starts a new access; the Z80 must drop zreq.
//  BG deasserted while in OWN/STROBE: ignored (BGACK held).
//  bank_wr together with zreq: the latched bank is the pre-shift value.
// CONFIGURATION
//  ZBANK_TIMEOUT_EN defined: 8-bit counter runs in STROBE.
//   At DTACK_TIMEOUT with no DTACK -> END, read data 8'hFF, timeout_err=1.
//  Not defined: no counter; STROBE waits for DTACK indefinitely; timeout_err tied 0.
// TESTING
//  9 bank_wr with bits 1,0,0,0,0,0,0,0,1 -> bank=9'h101; va_o for za=0x1234 = 23'h40491A.
//  Read za=0x0000, BG low after 3 cycles, DTACK after 2, vd_i=16'hABCD -> zd_o=8'hAB, zdone once.
//  Write za=0x0001, zd_i=8'h5A -> lds_o=0, uds_o=1, rw_o=0, vd_o=16'h5A5A, WAIT_pull released after END.
//  BGACK_i=0 held 10 cycles during REQ -> stays REQ with BR_pull=1; proceeds after release.
//  ZBANK_TIMEOUT_EN, DTACK never low -> after 255 STROBE cycles zd_o=8'hFF, timeout_err=1.
//  SRES low during STROBE -> next edge: bus_d=1, all strobes 1, all *_pull 0, bank 0.

Source files
------------

// File: rtl/zbank_bus_sequencer.sv
// Z80 bank-window bridge: stalls the Z80, takes the 68k bus, runs one byte cycle, releases it.
// Optional DTACK watchdog enabled by defining ZBANK_TIMEOUT_EN.
module zbank_bus_sequencer #(
   parameter int STROBE_SETUP = 2
`ifdef ZBANK_TIMEOUT_EN
   ,
   parameter int DTACK_TIMEOUT = 255
`endif
) (
   input  logic        MCLK,
   input  logic        SRES,
   input  logic        zreq,
   input  logic        zwr,
   input  logic [14:0] za,
   input  logic [7:0]  zd_i,
   output logic [7:0]  zd_o,
   output logic        zdone,
   output logic        WAIT_pull,
   input  logic        bank_wr,
   input  logic        bank_bit,
   output logic        BR_pull,
   input  logic        BG,
   input  logic        BGACK_i,
   output logic        BGACK_pull,
   input  logic        AS_i,
   output logic [22:0] va_o,
   input  logic [15:0] vd_i,
   output logic [15:0] vd_o,
   output logic        bus_d,
   output logic        vd_d,
   output logic        as_o,
   output logic        uds_o,
   output logic        lds_o,
   output logic        rw_o,
   input  logic        DTACK_i,
   output logic        timeout_err
);

   typedef enum logic [2:0] {IDLE, REQ, OWN, STROBE, END} state_t;

   localparam logic [7:0] SETUP_LAST = 8'(STROBE_SETUP - 1);
`ifdef ZBANK_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(DTACK_TIMEOUT - 1);
`endif

   state_t      state, state_next;
   logic [8:0]  bank, bank_q;
   logic [14:0] za_q;
   logic        zwr_q;
   logic [7:0]  zd_q;
   logic [7:0]  cnt, cnt_next;
   logic        start, owned, dtack_hit, to_hit;

   // A new access is not accepted in the zdone cycle so the Z80 has time to drop zreq.
   assign start = (state == IDLE) && zreq && !zdone;
   assign owned = (state == OWN) || (state == STROBE) || (state == END);

   always_comb begin
      state_next = state;
      cnt_next   = '0;
      dtack_hit  = 1'b0;
      to_hit     = 1'b0;
      case (state)
         IDLE:    if (start) state_next = REQ;
         REQ:     if (!BG && BGACK_i && AS_i) state_next = OWN;
         OWN: begin
            if (cnt == SETUP_LAST) state_next = STROBE;
            else cnt_next = cnt + 8'd1;
         end
         STROBE: begin
            if (!DTACK_i) begin
               dtack_hit  = 1'b1;
               state_next = END;
            end
`ifdef ZBANK_TIMEOUT_EN
            else if (cnt == TIMEOUT_LAST) begin
               to_hit     = 1'b1;
               state_next = END;
            end else begin
               cnt_next = cnt + 8'd1;
            end
`endif
         end
         END:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bus-facing outputs are zero when released because they are ORed onto shared nets.
   always_comb begin
      WAIT_pull  = start || (state != IDLE);
      BR_pull    = (state == REQ);
      BGACK_pull = owned;
      bus_d      = !owned;
      va_o       = owned ? {bank_q, za_q[14:1]} : '0;
      as_o       = !(state == STROBE);
      uds_o      = !((state == STROBE) && !za_q[0]);
      lds_o      = !((state == STROBE) && za_q[0]);
      rw_o       = !((state == STROBE) && zwr_q);
      vd_d       = !((state == STROBE) && zwr_q);
      vd_o       = vd_d ? 16'h0000 : {zd_q, zd_q};
   end

   always_ff @(posedge MCLK) begin
      if (!SRES) begin
         state  <= IDLE;
         bank   <= '0;
         bank_q <= '0;
         za_q   <= '0;
         zwr_q  <= 1'b0;
         zd_q   <= '0;
         cnt    <= '0;
         zd_o   <= 8'hFF;
         zdone  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         zdone <= (state == END);
         if (bank_wr) bank <= {bank_bit, bank[8:1]};
         if (start) begin
            za_q   <= za;
            zwr_q  <= zwr;
            zd_q   <= zd_i;
            bank_q <= bank;
         end
         if (dtack_hit && !zwr_q) zd_o <= za_q[0] ? vd_i[7:0] : vd_i[15:8];
         else if (to_hit) zd_o <= 8'hFF;
      end
   end

`ifdef ZBANK_TIMEOUT_EN
   always_ff @(posedge MCLK) begin
      if (!SRES) timeout_err <= 1'b0;
      else if (to_hit) timeout_err <= 1'b1;
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule
